// File: rtl/multi_7.sv
// Twiddle multiplier between the radix-8 ranks of a 64-point FFT: lanes 1..7 times W64^(k*j).
// Build option MULTI7_SAT_EN: clamp results to the DW-bit range instead of wrapping.
module multi_7 #(
  parameter int DW   = 10,
  parameter int CW   = 10,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      k,
  input  logic [7*DW-1:0] re_in,
  input  logic [7*DW-1:0] im_in,
  output logic            out_valid,
  output logic [7*DW-1:0] re_out,
  output logic [7*DW-1:0] im_out
);

  localparam int PW = DW + CW + 1;
  localparam logic signed [PW-1:0] Rnd = PW'(2 ** (FRAC - 1));
`ifdef MULTI7_SAT_EN
  localparam logic signed [PW-1:0] Max = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] Min = PW'(-(2 ** (DW - 1)));
`endif

  logic [7*DW-1:0] re_q, im_q, re_nxt, im_nxt;
  logic [2:0]      k_q;
  logic            v_q;

  // round(256*cos(2*pi*i/64)) for i = 0..16; sin comes from the mirrored index
  function automatic logic [8:0] qtab(input logic [4:0] i);
    logic [8:0] v;
    case (i)
      5'd0:    v = 9'd256;
      5'd1:    v = 9'd255;
      5'd2:    v = 9'd251;
      5'd3:    v = 9'd245;
      5'd4:    v = 9'd237;
      5'd5:    v = 9'd226;
      5'd6:    v = 9'd213;
      5'd7:    v = 9'd198;
      5'd8:    v = 9'd181;
      5'd9:    v = 9'd162;
      5'd10:   v = 9'd142;
      5'd11:   v = 9'd121;
      5'd12:   v = 9'd98;
      5'd13:   v = 9'd74;
      5'd14:   v = 9'd50;
      5'd15:   v = 9'd25;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] limit(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + Rnd) >>> FRAC;
`ifdef MULTI7_SAT_EN
    if (r > Max) begin
      r = Max;
    end else if (r < Min) begin
      r = Min;
    end
`endif
    return r[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
      k_q  <= '0;
      v_q  <= 1'b0;
    end else begin
      re_q <= re_in;
      im_q <= im_in;
      k_q  <= k;
      v_q  <= in_valid;
    end
  end

  always_comb begin
    logic [5:0]           e;
    logic signed [CW-1:0] cp, sp, wr, wi;
    logic signed [DW-1:0] a, b;
    logic signed [PW-1:0] pr, pi;
    re_nxt = '0;
    im_nxt = '0;
    e  = '0;
    cp = '0;
    sp = '0;
    wr = '0;
    wi = '0;
    a  = '0;
    b  = '0;
    pr = '0;
    pi = '0;
    for (int j = 1; j <= 7; j++) begin
      e  = 6'(int'(k_q) * j);
      cp = CW'($signed({1'b0, qtab({1'b0, e[3:0]})}));
      sp = CW'($signed({1'b0, qtab(5'd16 - {1'b0, e[3:0]})}));
      // quadrant symmetry: wr = cos, wi = -sin
      unique case (e[5:4])
        2'd0: begin wr = cp;  wi = -sp; end
        2'd1: begin wr = -sp; wi = -cp; end
        2'd2: begin wr = -cp; wi = sp;  end
        2'd3: begin wr = sp;  wi = cp;  end
      endcase
      a  = $signed(re_q[DW*(j-1) +: DW]);
      b  = $signed(im_q[DW*(j-1) +: DW]);
      pr = PW'(a) * PW'(wr) - PW'(b) * PW'(wi);
      pi = PW'(a) * PW'(wi) + PW'(b) * PW'(wr);
      re_nxt[DW*(j-1) +: DW] = limit(pr);
      im_nxt[DW*(j-1) +: DW] = limit(pi);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_out    <= '0;
      im_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      re_out    <= re_nxt;
      im_out    <= im_nxt;
      out_valid <= v_q;
    end
  end

endmodule

// File: tb/tb_multi_7.sv
// Bench for multi_7: vector table through a scoreboard queue, plus reset corner sequences.
module tb_multi_7;
  localparam int DW = 10;
  localparam int NV = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [2:0]      k;
  logic [7*DW-1:0] re_in, im_in, re_out, im_out;
  logic            out_valid;

  always #5 clk = ~clk;

  multi_7 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .k        (k),
    .re_in    (re_in),
    .im_in    (im_in),
    .out_valid(out_valid),
    .re_out   (re_out),
    .im_out   (im_out)
  );

  typedef struct {
    logic [2:0]  k;
    logic        v;
    logic [69:0] re, im, exp_re, exp_im;
  } vec_t;

  typedef struct {
    int          due;
    logic        v;
    logic [69:0] re, im;
  } sb_t;

  vec_t tbl[NV];
  sb_t  sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Reference: exact trig rounded to Q1.8, wide integer arithmetic
  function automatic logic [69:0] model(input logic [69:0] re, input logic [69:0] im,
                                        input logic [2:0] kk, input bit imag);
    logic [69:0] res;
    int          a, b, e, wr, wi;
    real         ang;
    longint      p, r;
    res = '0;
    for (int j = 1; j <= 7; j++) begin
      a   = int'($signed(re[10*(j-1) +: 10]));
      b   = int'($signed(im[10*(j-1) +: 10]));
      e   = (int'(kk) * j) % 64;
      ang = 2.0 * 3.14159265358979 * e / 64.0;
      wr  = rnd(256.0 * $cos(ang));
      wi  = -rnd(256.0 * $sin(ang));
      p   = imag ? (longint'(a) * wi + longint'(b) * wr) : (longint'(a) * wr - longint'(b) * wi);
      r   = (p + 128) >>> 8;
`ifdef MULTI7_SAT_EN
      if (r > 511) r = 511;
      if (r < -512) r = -512;
`endif
      res[10*(j-1) +: 10] = r[9:0];
    end
    return res;
  endfunction

  function automatic logic [69:0] rand_bus();
    logic [69:0] res;
    for (int j = 0; j < 7; j++) res[10*j +: 10] = 10'($urandom_range(0, 1023));
    return res;
  endfunction

  task automatic drive(input logic [2:0] kk, input logic vv, input logic [69:0] r,
                       input logic [69:0] i, input logic [69:0] er, input logic [69:0] ei);
    @(posedge clk);
    #1;
    k        = kk;
    in_valid = vv;
    re_in    = r;
    im_in    = i;
    sb.push_back('{cyc + 2, vv, er, ei});
  endtask

  always @(negedge clk) begin
    sb_t it;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      chk("out_valid", {69'd0, out_valid}, {69'd0, it.v});
      chk("re_out", re_out, it.re);
      chk("im_out", im_out, it.im);
    end else begin
      chk("idle out_valid", {69'd0, out_valid}, 70'd0);
    end
  end

  initial begin
    logic [69:0] r, i;
    // table: inputs first, expectations from the model, spec constants on top
    for (int n = 0; n < NV; n++) begin
      tbl[n].v  = 1'b1;
      tbl[n].k  = 3'(n);
      tbl[n].re = rand_bus();
      tbl[n].im = rand_bus();
    end
    tbl[0].k = 3'd0; tbl[0].re = {7{10'd100}}; tbl[0].im = '0;
    tbl[1].k = 3'd2; tbl[1].re = {7{10'd100}}; tbl[1].im = '0;
    tbl[2].k = 3'd4; tbl[2].re = {7{10'd100}}; tbl[2].im = '0;
    tbl[3].k = 3'd2; tbl[3].re = '0; tbl[3].im = '0;
    tbl[3].re[30 +: 10] = 10'h200;
    tbl[3].im[30 +: 10] = 10'h200;
    for (int n = 4; n < 12; n++) tbl[n].k = 3'(n - 4);
    for (int n = 12; n < 16; n++) begin
      tbl[n].k = 3'($urandom_range(0, 7));
      tbl[n].v = 1'($urandom_range(0, 1));
    end
    tbl[16].k = 3'd3; tbl[16].re = {7{10'h200}}; tbl[16].im = {7{10'h200}};
    tbl[17].k = 3'd5; tbl[17].re = {7{10'h1FF}}; tbl[17].im = {7{10'h1FF}};
    tbl[18].k = 3'd7; tbl[18].re = {7{10'h1FF}}; tbl[18].im = {7{10'h200}};
    for (int n = 0; n < NV; n++) begin
      tbl[n].exp_re = model(tbl[n].re, tbl[n].im, tbl[n].k, 1'b0);
      tbl[n].exp_im = model(tbl[n].re, tbl[n].im, tbl[n].k, 1'b1);
    end
    tbl[0].exp_re = {7{10'd100}};
    tbl[0].exp_im = '0;
    tbl[1].exp_re[30 +: 10] = 10'd71;  tbl[1].exp_im[30 +: 10] = -10'sd71;
    tbl[1].exp_re[60 +: 10] = 10'd20;  tbl[1].exp_im[60 +: 10] = -10'sd98;
    tbl[2].exp_re[30 +: 10] = 10'd0;   tbl[2].exp_im[30 +: 10] = -10'sd100;
    tbl[2].exp_re[10 +: 10] = 10'd71;  tbl[2].exp_im[10 +: 10] = -10'sd71;
`ifdef MULTI7_SAT_EN
    tbl[3].exp_re[30 +: 10] = 10'h200;
`else
    tbl[3].exp_re[30 +: 10] = 10'd300;
`endif
    tbl[3].exp_im[30 +: 10] = 10'd0;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    k        = '0;
    re_in    = '0;
    im_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {69'd0, out_valid}, 70'd0);
    chk("reset re_out", re_out, 70'd0);
    chk("reset im_out", im_out, 70'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < NV; n++)
      drive(tbl[n].k, tbl[n].v, tbl[n].re, tbl[n].im, tbl[n].exp_re, tbl[n].exp_im);

    // reset while groups are in flight: outputs clear without a clock edge
    for (int n = 0; n < 3; n++) begin
      r = rand_bus();
      i = rand_bus();
      drive(3'(n + 1), 1'b1, r, i, model(r, i, 3'(n + 1), 1'b0), model(r, i, 3'(n + 1), 1'b1));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {69'd0, out_valid}, 70'd0);
    chk("async rst re_out", re_out, 70'd0);
    chk("async rst im_out", im_out, 70'd0);
    sb.delete();
    in_valid = 1'b0;
    k        = '0;
    re_in    = '0;
    im_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    r = {7{10'd100}};
    i = '0;
    drive(3'd2, 1'b1, r, i, model(r, i, 3'd2, 1'b0), model(r, i, 3'd2, 1'b1));
    drive(3'd0, 1'b0, '0, '0, '0, '0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d groups never emerged, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
